hazard_light_ctrl: RTL and testbench

//  Sequencer for the 3-LED hazard-light display (LEDR[2:0]).
//  - Divides clk down to a step tick.
//  - Synchronises the 2-bit mode switches.
//  - Runs the pattern state machine that decides which LEDs are lit on each step.
//  - Sits between the board switch inputs and the LED outputs; the consecutive-input

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_light_ctrl_tick_gen.sv | 46 ++++
 rtl/hazard_light_ctrl.sv | 95 +++++++++
 tb/tb_hazard_light_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard-light display: mode decode, pattern states, reset pattern.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

  // Synchronised mode-switch value; RSVD behaves exactly like CALM.
  typedef enum logic [1:0] {
    CALM = 2'b00,
    R2L  = 2'b01,
    L2R  = 2'b10,
    RSVD = 2'b11
  } mode_t;

  // Pattern states; each encoding is the LED pattern shown (bit2 = leftmost LED).
  typedef enum logic [2:0] {
    CENTER = 3'b010,
    OUT    = 3'b101,
    LEFT   = 3'b100,
    RIGHT  = 3'b001
  } state_t;

  localparam logic [2:0] LED_RESET = 3'b010;

endpackage

// File: rtl/hazard_light_ctrl_tick_gen.sv
// Prescaler: pulses tick for one cycle every DIV enabled clk cycles.
// Latency: combinational tick from the counter; first tick on the DIV-th enabled cycle after reset.
// Backpressure: en=0 freezes the count and suppresses tick; no other stall input.
//
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous active-high reset, clears the count
//   en    in  1  count enable
//   tick  out 1  high in the enabled cycle where the count wraps
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  // Derived width; DIV=1 still needs a 1-bit counter that simply stays at zero.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);
  // en gates the tick combinationally so dropping en in the wrap cycle cancels the step.
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_light_ctrl.sv
// Hazard-light sequencer: syncs the mode switches, divides clk to a step tick, steps the LED pattern.
// Latency: mode lags sw by 2 clk; led and tick update 1 clk after the prescaler wrap.
// Backpressure: en=0 freezes prescaler, pattern and tick; the switch synchroniser keeps running.
//
// Ports:
//   clk   in  1  system clock
//   reset in  1  synchronous active-high reset
//   sw    in  2  mode select, asynchronous to clk (00 calm, 01 R2L, 10 L2R, 11 as calm)
//   en    in  1  run enable
//   led   out 3  registered pattern, bit2 = leftmost LED
//   tick  out 1  one-cycle pulse coincident with each led step
module hazard_light_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw,
  input  logic       en,
  output logic [2:0] led,
  output logic       tick
);

  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  mode_t      mode;
  logic       tick_int;
  state_t     state_q;
  state_t     state_d;
  logic       tick_q;

  // Two-flop synchroniser for the switch inputs; not gated by en.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign mode = mode_t'(sync2_q);

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick_int)
  );

  // Next pattern. Only a tick advances the pattern; the mode seen in the tick cycle picks the step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CENTER: begin
        if (tick_int) begin
          case (mode)
            R2L:     state_d = LEFT;
            L2R:     state_d = RIGHT;
            default: state_d = OUT;
          endcase
        end
      end
      OUT: begin
        if (tick_int) state_d = CENTER;
      end
      LEFT: begin
        if (tick_int) state_d = (mode == R2L) ? RIGHT : CENTER;
      end
      RIGHT: begin
        if (tick_int) state_d = (mode == L2R) ? LEFT : CENTER;
      end
      // Unreachable encodings recover straight to the centre pattern.
      default: state_d = CENTER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_t'(LED_RESET);
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_int;
    end
  end

  assign led  = state_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_hazard_light_ctrl.sv
module tb_hazard_light_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [1:0] sw;
  logic       en;
  logic [2:0] led;
  logic       tick;

  int n_checks;
  int n_pass;

  // Reference model state
  bit         m_valid;
  logic [2:0] m_led;
  logic       m_tick;
  int         m_en_cnt;
  logic [1:0] sw_hist1;
  logic [1:0] sw_hist2;

  hazard_light_ctrl #(.DIV(DIV)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .en   (en),
    .led  (led),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
  endtask

  // Pattern rules: calm alternates centre/outer pair; a directional mode walks a 3-position
  // ring; anything off the ring re-enters at the centre.
  function automatic logic [2:0] model_next(input logic [2:0] s, input logic [1:0] m);
    logic [2:0] ring [3];
    if (m == 2'b01) begin
      ring[0] = 3'b010; ring[1] = 3'b100; ring[2] = 3'b001;
    end else if (m == 2'b10) begin
      ring[0] = 3'b010; ring[1] = 3'b001; ring[2] = 3'b100;
    end else begin
      return (s == 3'b010) ? 3'b101 : 3'b010;
    end
    for (int i = 0; i < 3; i++) begin
      if (ring[i] == s) return ring[(i + 1) % 3];
    end
    return 3'b010;
  endfunction

  // Model update: the mode in force is the switch value sampled two edges ago;
  // a step happens on every DIV-th enabled cycle since reset.
  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1'b1;
      m_led    = 3'b010;
      m_tick   = 1'b0;
      m_en_cnt = 0;
      sw_hist1 = 2'b00;
      sw_hist2 = 2'b00;
    end else begin
      bit step;
      step = 1'b0;
      if (en) begin
        m_en_cnt++;
        step = (m_en_cnt % DIV) == 0;
      end
      if (step) m_led = model_next(m_led, sw_hist2);
      m_tick   = step;
      sw_hist2 = sw_hist1;
      sw_hist1 = sw;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("led", led, m_led);
      chk("tick", {2'b00, tick}, {2'b00, m_tick});
    end
  end

  // Apply inputs at a negedge, hold for n rising edges, return at a negedge.
  task automatic run(input logic r, input logic [1:0] s, input logic e, input int n);
    reset = r;
    sw    = s;
    en    = e;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_valid  = 1'b0;
    reset    = 1'b1;
    sw       = 2'b00;
    en       = 1'b1;
    @(negedge clk);

    // 1: calm after a 3-cycle reset
    run(1'b1, 2'b00, 1'b1, 3);
    chk("t1_rst_led", led, 3'b010);
    chk("t1_rst_tick", {2'b00, tick}, 3'b000);
    run(1'b0, 2'b00, 1'b1, 3);
    chk("t1_pre_led", led, 3'b010);
    run(1'b0, 2'b00, 1'b1, 1);
    chk("t1_step1_led", led, 3'b101);
    chk("t1_step1_tick", {2'b00, tick}, 3'b001);
    run(1'b0, 2'b00, 1'b1, 1);
    chk("t1_pulse_width", {2'b00, tick}, 3'b000);
    run(1'b0, 2'b00, 1'b1, 3);
    chk("t1_step2_led", led, 3'b010);

    // 2: right-to-left
    run(1'b1, 2'b01, 1'b1, 1);
    run(1'b0, 2'b01, 1'b1, 4);
    chk("t2_s1", led, 3'b100);
    run(1'b0, 2'b01, 1'b1, 4);
    chk("t2_s2", led, 3'b001);
    run(1'b0, 2'b01, 1'b1, 4);
    chk("t2_s3", led, 3'b010);
    run(1'b0, 2'b01, 1'b1, 4);
    chk("t2_s4", led, 3'b100);

    // 3: left-to-right, then back to calm while at 001
    run(1'b1, 2'b10, 1'b1, 1);
    run(1'b0, 2'b10, 1'b1, 4);
    chk("t3_s1", led, 3'b001);
    run(1'b0, 2'b10, 1'b1, 4);
    chk("t3_s2", led, 3'b100);
    run(1'b0, 2'b10, 1'b1, 4);
    chk("t3_s3", led, 3'b010);
    run(1'b0, 2'b10, 1'b1, 4);
    chk("t3_s4", led, 3'b001);
    run(1'b0, 2'b00, 1'b1, 4);
    chk("t3_calm1", led, 3'b010);
    run(1'b0, 2'b00, 1'b1, 4);
    chk("t3_calm2", led, 3'b101);

    // 4: freeze for 10 cycles with 2 counts already taken
    run(1'b1, 2'b00, 1'b1, 1);
    run(1'b0, 2'b00, 1'b1, 2);
    run(1'b0, 2'b00, 1'b0, 10);
    chk("t4_frozen_led", led, 3'b010);
    chk("t4_frozen_tick", {2'b00, tick}, 3'b000);
    run(1'b0, 2'b00, 1'b1, 1);
    chk("t4_resid_led", led, 3'b010);
    run(1'b0, 2'b00, 1'b1, 1);
    chk("t4_resume_led", led, 3'b101);

    // 5: reset one cycle before a tick while at 100
    run(1'b1, 2'b01, 1'b1, 1);
    run(1'b0, 2'b01, 1'b1, 4);
    chk("t5_at_left", led, 3'b100);
    run(1'b0, 2'b01, 1'b1, 3);
    run(1'b1, 2'b01, 1'b1, 1);
    chk("t5_rst_led", led, 3'b010);
    chk("t5_rst_tick", {2'b00, tick}, 3'b000);
    run(1'b0, 2'b01, 1'b1, 3);
    chk("t5_wait_led", led, 3'b010);
    run(1'b0, 2'b01, 1'b1, 1);
    chk("t5_step_led", led, 3'b100);

    // 6: reserved mode behaves as calm; late toggle is not seen yet
    run(1'b1, 2'b11, 1'b1, 1);
    run(1'b0, 2'b11, 1'b1, 4);
    chk("t6_s1", led, 3'b101);
    run(1'b0, 2'b11, 1'b1, 4);
    chk("t6_s2", led, 3'b010);
    run(1'b0, 2'b11, 1'b1, 2);
    run(1'b0, 2'b01, 1'b1, 2);
    chk("t6_late_toggle", led, 3'b101);

    // Randomised phase
    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [1:0] s;
      logic       e;
      r = ($urandom_range(0, 49) == 0);
      s = 2'($urandom_range(0, 3));
      e = ($urandom_range(0, 9) != 0);
      run(r, s, e, $urandom_range(1, 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
